// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg
//   Shared definitions for the FFT job sequencer: FSM state encoding,
//   config-word width helper and timeout counter width.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMMIT,
    S_CFG_WAIT,
    S_TRIG,
    S_STREAM,
    S_RESULT,
    S_DONE
  } state_t;

  localparam int unsigned TO_CNT_W = 16;

  // Config word is {scaleSch, forward}.
  function automatic int unsigned calc_cfg_w(input int unsigned scale_w);
    return scale_w + 1;
  endfunction

endpackage

// File: rtl/fft_rr_arbiter.sv
// fft_rr_arbiter
//   Combinational round-robin arbiter. Search starts at last_grant+1 and
//   wraps modulo NREQ; the first asserted request wins.
// Ports:
//   req        in  NREQ   request vector
//   last_grant in  IDX_W  index granted most recently (owned by the caller)
//   en         in  1      arbitration enable; grant is all-zero when low
//   grant      out NREQ   one-hot grant
//   grant_idx  out IDX_W  index of the granted requester
module fft_rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDX_W'((32'(last_grant) + k) % NREQ);
      if (en && !w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_job_sequencer.sv
// fft_job_sequencer
//   Shares one FFT engine between NREQ requesters. Accepts a job
//   round-robin, latches the winner's config word, then sequences
//   config commit -> config handshake -> input trigger -> streaming ->
//   result, and reports completion (or timeout) to the winner.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_cfg      per-requester job request and config word
//   req_ready              one-hot acceptance (combinational, IDLE only)
//   done/done_err          one-cycle completion pulse; err=1 on timeout
//   busy                   high whenever not IDLE
//   cfg_word/cfg_commit    config to the FFT config block and commit pulse
//   cfg_tvalid/cfg_tready  config AXIS handshake monitor
//   in_trig/in_streaming   input-stream trigger and streaming flag
//   out_received           output block frame-received pulse
module fft_job_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned SCALE_SCH_WIDTH = 4,
  parameter int unsigned CFG_W           = calc_cfg_w(SCALE_SCH_WIDTH),
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CFG_W-1:0] req_cfg,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       done,
  output logic                  done_err,
  output logic                  busy,
  output logic [CFG_W-1:0]      cfg_word,
  output logic                  cfg_commit,
  input  logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic                  in_trig,
  input  logic                  in_streaming,
  input  logic                  out_received
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
  // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES, so the
  // registered done lands exactly TIMEOUT_CYCLES cycles after entering the wait.
  localparam logic [TO_CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_next;
  logic [IDX_W-1:0]      r_last, r_gidx, w_gidx;
  logic [NREQ-1:0]       w_grant;
  logic [TO_CNT_W-1:0]   r_cnt;
  logic                  r_seen_hi, r_sticky;
  logic                  w_wait, w_ev, w_timeout, w_accept;
  logic [CFG_W-1:0]      w_cfg_sel;

  fft_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last),
    .en         ((r_state == S_IDLE) && !reset),
    .grant      (w_grant),
    .grant_idx  (w_gidx)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_cfg_sel = req_cfg[w_gidx*CFG_W +: CFG_W];

  always_comb begin
    w_next = r_state;
    w_ev   = 1'b0;
    unique case (r_state)
      S_IDLE:     if (w_accept) w_next = S_COMMIT;
      S_COMMIT:   w_next = S_CFG_WAIT;
      S_CFG_WAIT: begin
        w_ev = cfg_tvalid && cfg_tready;
        if (w_ev) w_next = S_TRIG;
      end
      S_TRIG:     w_next = S_STREAM;
      S_STREAM: begin
        w_ev = r_seen_hi && !in_streaming;
        if (w_ev) w_next = S_RESULT;
      end
      S_RESULT: begin
        w_ev = out_received || r_sticky;
        if (w_ev) w_next = S_DONE;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    w_wait    = (r_state == S_CFG_WAIT) || (r_state == S_STREAM) ||
                (r_state == S_RESULT);
    // Awaited event takes priority over a coincident timeout.
    w_timeout = (TIMEOUT_CYCLES != 0) && w_wait && !w_ev && (r_cnt == TO_LAST);
    if (w_timeout) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last     <= LAST_RST;
      r_gidx     <= '0;
      cfg_word   <= CFG_W'(1);
      r_cnt      <= '0;
      r_seen_hi  <= 1'b0;
      r_sticky   <= 1'b0;
      done       <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
      cfg_commit <= 1'b0;
      in_trig    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gidx   <= w_gidx;
        cfg_word <= w_cfg_sel;
      end
      if ((r_state == S_DONE) || w_timeout) r_last <= r_gidx;

      if (w_next != r_state) r_cnt <= '0;
      else if (w_wait)       r_cnt <= r_cnt + 1'b1;

      r_seen_hi <= (r_state == S_STREAM) && (r_seen_hi || in_streaming);
      // Result pulses outside STREAM/RESULT are stale and never recorded.
      r_sticky  <= ((r_state == S_STREAM) && out_received) ||
                   (r_sticky && (r_state != S_IDLE));

      done     <= ((w_next == S_DONE) || w_timeout) ? (NREQ'(1) << r_gidx) : '0;
      done_err <= w_timeout;
      busy       <= (w_next != S_IDLE);
      cfg_commit <= (w_next == S_COMMIT);
      in_trig    <= (w_next == S_TRIG);
    end
  end

endmodule

// File: doc/fft_job_sequencer.md
# fft_job_sequencer

Scheduler that shares the single FFT engine between `NREQ` requesters. It arbitrates requests round-robin and latches the winner's FFT configuration word. It then runs the engine through config commit, input trigger and result wait, and reports completion or timeout back to the winning requester. It sits between the requester-side control logic and the FFT config and data-input/data-output blocks, and drives their `commit`/`trig` pulses.

## Interface

- `NREQ`, 2: number of requesters, 2..8.
- `SCALE_SCH_WIDTH`, 4: scale schedule width.
- `CFG_W`, `SCALE_SCH_WIDTH+1`: config word width, `{scaleSch, forward}`.
- `TIMEOUT_CYCLES`, 65535: per-wait timeout; 0 disables the timeout.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NREQ`: per-requester job request; held high until accepted.
- `req_cfg` in `NREQ*CFG_W`: per-requester config word; slice i is `[i*CFG_W +: CFG_W]`.
- `req_ready` out `NREQ`: one-hot acceptance.
- `done` out `NREQ`: one-cycle completion pulse for the granted requester.
- `done_err` out 1: qualifies `done`; 1 means timeout.
- `busy` out 1: high in every state except IDLE.
- `cfg_word` out `CFG_W`: feeds the FFT config scaleSch/forward inputs.
- `cfg_commit` out 1: one-cycle commit pulse.
- `cfg_tvalid` in 1: monitor of the config AXIS valid.
- `cfg_tready` in 1: monitor of the config AXIS ready.
- `in_trig` out 1: one-cycle input-stream trigger.
- `in_streaming` in 1: input block streaming flag.
- `out_received` in 1: output block frame-received pulse.

## Operation

- States: IDLE, COMMIT, CFG_WAIT, TRIG, STREAM, RESULT, DONE.
- IDLE:
  - If any `req_valid` is set, grant index g, chosen round-robin starting at `last_grant+1` modulo `NREQ`.
  - Assert `req_ready[g]` combinationally in this cycle.
  - Latch `req_cfg[g]` into `cfg_word` and record g.
  - Go to COMMIT.
- COMMIT: `cfg_commit`=1 for one cycle, then go to CFG_WAIT.
- CFG_WAIT: wait for `cfg_tvalid && cfg_tready`, then go to TRIG.
- TRIG: `in_trig`=1 for one cycle, then go to STREAM.
- STREAM:
  - Wait until `in_streaming` has been seen high and then low, then go to RESULT.
  - If `out_received` arrives during STREAM, record it in a sticky flag.
- RESULT: go to DONE on `out_received` or when the sticky flag is set.
- DONE:
  - `done[g]`=1 for one cycle, with `done_err`=0.
  - Set `last_grant`=g and return to IDLE.
- Timeout:
  - A 16-bit counter runs in CFG_WAIT, STREAM and RESULT, and clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`, pulse `done[g]` with `done_err`=1 and go directly to IDLE.
  - `last_grant` is still updated to g.
  - If the awaited event and the timeout occur in the same cycle, the event wins.
- `out_received` seen in IDLE, COMMIT, CFG_WAIT or TRIG is stale and is ignored.
- `cfg_word` holds its value between jobs; it changes only at acceptance.
- `req_valid` dropping after acceptance has no effect on the running job.

## Timing

- Reset values:
  - state IDLE; `last_grant`=`NREQ-1`, so the first grant after reset goes to index 0.
  - `cfg_word`=1 (forward, scale 0).
  - `req_ready`, `done`, `done_err`, `busy`, `cfg_commit` and `in_trig` all 0.
  - Counter and sticky flag cleared.
- `reset` asserted mid-job aborts immediately with no `done` pulse; the next cycle is IDLE.
- Acceptance cycle N: `cfg_commit` at N+1; `in_trig` at N+3 at the earliest, when the config handshake is seen at N+2.
- `done` is asserted in the cycle after RESULT sees its event, so `out_received` at cycle M gives `done` at M+1.
- `busy` is registered. It rises the cycle after acceptance and falls the cycle after DONE.
- Back-to-back jobs: at most one new acceptance every (job length + 1) cycles.
- Every output except `req_ready` is registered.

## Structure

- Package `fft_seq_pkg`: state enum, `CFG_W` computation, timeout counter width (16).
- Sub-module `fft_rr_arbiter`:
  - Parameter `NREQ`.
  - Inputs: `req`, `last_grant`, `en`.
  - Outputs: one-hot `grant` and its index.
  - Purely combinational; the FSM owns `last_grant`.

## Test plan

- Single job from req0 with cfg=0x0B: `cfg_word`=0x0B and one-cycle commit; config handshake → `in_trig` pulse; streaming high 16 cycles then low; `out_received` → `done`=0b01, `done_err`=0.
- req0 and req1 held continuously: grants alternate 0,1,0,1 across 4 jobs; each `done` lands on the correct bit.
- `TIMEOUT_CYCLES`=20 with `cfg_tready` held low: `done[g]`=1 and `done_err`=1 exactly 20 cycles after entering CFG_WAIT; `in_trig` is never asserted.
- `out_received` pulses during STREAM, before streaming falls: `done` at the cycle after STREAM exits.
- Stale `out_received` injected during CFG_WAIT: ignored; the job still waits for the real result.
- `reset` asserted in RESULT: no `done`; `busy`=0 the next cycle; the next grant goes to req0 with `cfg_word` replaced by the new request's config.
